// File: rtl/clcg_word_packer.sv
// rtl/clcg_word_packer.sv - serial-to-parallel packer for the dual-CLCG bit stream
// Newest bit lands in the LSB; one-word output slot plus packing register buffer up to 2N bits.
module clcg_word_packer #(
  parameter int N    = 4,
  parameter int SKIP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
  localparam logic [CW-1:0] C_FULL = CW'(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [SW-1:0] C_SKIP = SW'(SKIP);

  logic [N-1:0]  r_sr;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_skip;
  logic [N-1:0]  r_word_out;
  logic          r_word_valid;

  logic          w_hold;
  logic          w_accept;
  logic          w_slot_free;
  logic          w_pop;
  logic [N-1:0]  w_next_sr;

  // bit_ready depends on registered cnt only, so no input reaches it combinationally.
  assign w_hold      = (r_cnt == C_FULL);
  assign bit_ready   = !w_hold;
  assign w_accept    = bit_valid && !w_hold;
  assign w_slot_free = !r_word_valid || word_ready;
  assign w_pop       = r_word_valid && word_ready;
  assign w_next_sr   = {r_sr[N-2:0], bit_in};

  assign word_out    = r_word_out;
  assign word_valid  = r_word_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_skip       <= C_SKIP;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
    end else begin
      // A pop clears the slot unless a transfer below refills it in the same cycle.
      if (w_pop) begin
        r_word_valid <= 1'b0;
      end

      if (w_hold) begin
        if (w_slot_free) begin
          r_word_out   <= r_sr;
          r_word_valid <= 1'b1;
          r_cnt        <= '0;
        end
      end else if (w_accept) begin
        if (r_skip != '0) begin
          r_skip <= r_skip - 1'b1;
        end else if (r_cnt == C_LAST) begin
          if (w_slot_free) begin
            r_word_out   <= w_next_sr;
            r_word_valid <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_sr  <= w_next_sr;
            r_cnt <= C_FULL;
          end
        end else begin
          r_sr  <= w_next_sr;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clcg_word_packer.sv
// tb/tb_clcg_word_packer.sv - table-driven, hand-written and randomized checks of clcg_word_packer
module tb_clcg_word_packer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_in;
  logic         bit_valid;
  logic         word_ready;
  logic         rdy0, val0, rdy2, val2;
  logic [N-1:0] wo0, wo2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clcg_word_packer #(.N(N), .SKIP(0)) dut0 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy0),
    .word_out(wo0), .word_valid(val0), .word_ready(word_ready)
  );

  clcg_word_packer #(.N(N), .SKIP(2)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy2),
    .word_out(wo2), .word_valid(val2), .word_ready(word_ready)
  );

  typedef struct {
    bit       bv;
    bit       b;
    bit       wr;
    bit       e_ready;
    bit       e_valid;
    bit [3:0] e_word;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled on the following falling edge.
  task automatic step(input bit bv, input bit b, input bit wr);
    bit_valid  = bv;
    bit_in     = b;
    word_ready = wr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  function automatic void add(bit bv, bit b, bit wr, bit er, bit ev, bit [3:0] ew);
    vec_t v;
    v.bv = bv; v.b = b; v.wr = wr; v.e_ready = er; v.e_valid = ev; v.e_word = ew;
    vecs.push_back(v);
  endfunction

  // Reference model: accepted bits queue up until N are held, then move to the slot as a word.
  bit       m_q[$];
  int       m_skip;
  bit       m_v;
  bit [3:0] m_w;

  function automatic void model_reset(int skip);
    m_q.delete();
    m_skip = skip;
    m_v    = 1'b0;
    m_w    = '0;
  endfunction

  function automatic void model_step(bit bv, bit b, bit wr);
    bit free;
    bit newv;
    bit [3:0] w;
    free = !m_v || wr;
    newv = 1'b0;
    if (bv && m_q.size() < N) begin
      if (m_skip > 0) m_skip--;
      else m_q.push_back(b);
    end
    if (m_q.size() == N && free) begin
      w = '0;
      foreach (m_q[i]) w = {w[2:0], m_q[i]};
      m_w = w;
      m_q.delete();
      newv = 1'b1;
    end
    if (newv) m_v = 1'b1;
    else if (m_v && wr) m_v = 1'b0;
  endfunction

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", rdy0, 1);
    check("reset_valid", val0, 0);
    check("reset_word", wo0, 0);

    // basic word 1011 with word_ready high
    add(1,1,1, 1,0,4'b0000); add(1,0,1, 1,0,4'b0000); add(1,1,1, 1,0,4'b0000);
    add(1,1,1, 1,1,4'b1011); add(0,0,1, 1,0,4'b1011);
    // back-pressure: 1011 into slot, 0110 into sr, then stall
    add(1,1,0, 1,0,4'b1011); add(1,0,0, 1,0,4'b1011); add(1,1,0, 1,0,4'b1011);
    add(1,1,0, 1,1,4'b1011); add(1,0,0, 1,1,4'b1011); add(1,1,0, 1,1,4'b1011);
    add(1,1,0, 1,1,4'b1011); add(1,0,0, 0,1,4'b1011);
    add(1,1,1, 1,1,4'b0110); add(0,0,0, 1,1,4'b0110); add(0,0,1, 1,0,4'b0110);
    // gaps: invalid cycles carry 1s that must not enter sr
    add(1,0,1, 1,0,4'b0110); add(0,1,1, 1,0,4'b0110); add(0,1,1, 1,0,4'b0110);
    add(1,1,1, 1,0,4'b0110); add(1,1,1, 1,0,4'b0110); add(0,1,1, 1,0,4'b0110);
    add(1,0,1, 1,1,4'b0110); add(0,1,1, 1,0,4'b0110);
    // back-to-back: pop and new word on the same edge
    add(1,1,1, 1,0,4'b0110); add(1,0,1, 1,0,4'b0110); add(1,0,1, 1,0,4'b0110);
    add(1,1,0, 1,1,4'b1001); add(1,0,0, 1,1,4'b1001); add(1,1,0, 1,1,4'b1001);
    add(1,0,0, 1,1,4'b1001); add(1,0,1, 1,1,4'b0100); add(0,0,1, 1,0,4'b0100);

    foreach (vecs[i]) begin
      step(vecs[i].bv, vecs[i].b, vecs[i].wr);
      check($sformatf("vec%0d_ready", i), rdy0, vecs[i].e_ready);
      check($sformatf("vec%0d_valid", i), val0, vecs[i].e_valid);
      check($sformatf("vec%0d_word", i), wo0, vecs[i].e_word);
    end

    // reset mid-word discards the partial word and clears word_out
    step(1, 1, 1);
    step(1, 1, 1);
    do_reset();
    check("rst_mid_valid", val0, 0);
    check("rst_mid_word", wo0, 0);
    check("rst_mid_ready", rdy0, 1);
    step(1, 0, 1); step(1, 1, 1); step(1, 0, 1);
    check("rst_mid_no_early", val0, 0);
    step(1, 1, 1);
    check("rst_mid_valid2", val0, 1);
    check("rst_mid_word2", wo0, 4'b0101);

    // SKIP=2 instance drops the first two accepted bits
    do_reset();
    check("skip_reset_ready", rdy2, 1);
    step(1, 1, 1); step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 1, 1);
    check("skip_not_yet", val2, 0);
    step(1, 0, 1);
    check("skip_valid", val2, 1);
    check("skip_word", wo2, 4'b0010);

    // randomized run against the queue model, with occasional resets
    do_reset();
    model_reset(0);
    for (int c = 0; c < 4000; c++) begin
      bit bv, b, wr, r;
      check("rnd_ready", rdy0, (m_q.size() < N) ? 1 : 0);
      check("rnd_valid", val0, m_v);
      check("rnd_word", wo0, m_w);
      r  = ($urandom_range(0, 299) == 0);
      bv = ($urandom_range(0, 3) != 0);
      b  = $urandom_range(0, 1);
      wr = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst = r;
      if (r) model_reset(0);
      else model_step(bv, b, wr);
      step(bv, b, wr);
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
